// File: rtl/dcache_store_drain_pkg.sv
// -----------------------------------------------------------------------------
// dcache_store_drain_pkg
// Shared types for the committed-store drain buffer: the dcache request and
// response port structs, the buffered store entry, the drain FSM state
// encoding and a byte-lane merge helper used when STORE_MERGE_EN is defined.
// -----------------------------------------------------------------------------
package dcache_store_drain_pkg;

    localparam int unsigned DCACHE_INDEX_WIDTH     = 12;
    localparam int unsigned DCACHE_TAG_WIDTH       = 44;
    localparam int unsigned ST_DRAIN_ADDR_W        = 64;
    localparam int unsigned ST_DRAIN_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [ST_DRAIN_ADDR_W-1:0] addr;
        logic [63:0]                data;
        logic [7:0]                 be;
        logic [1:0]                 size;
    } st_drain_entry_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    // Replace the bytes of old_data selected by be with those of new_data.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                                input logic [63:0] new_data,
                                                input logic [7:0]  be);
        logic [63:0] r;
        r = old_data;
        for (int unsigned i = 0; i < 8; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_store_drain_fifo.sv
// -----------------------------------------------------------------------------
// st_drain_fifo
// In-order DEPTH x st_drain_entry_t store buffer with wrapping read/write
// pointers and a separate 0..DEPTH occupancy counter. The head stays in the
// buffer until popped, so the count includes the entry being issued.
// Optional STORE_MERGE_EN: a push whose double-word address matches the tail
// entry is folded into the tail instead of allocating, unless the tail is busy.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i            write push_entry_i (allocate or merge)
//   push_entry_i      incoming store
//   pop_i             retire the head
//   head_o / next_o   entry at read pointer and the one after it
//   count_o           occupied entries (0..DEPTH)
//   full_o            count_o == DEPTH
//   tail_busy_i       (merge) tail is, or is becoming, the issued entry
//   merge_cand_o      (merge) push address matches a buffered tail
//   merge_hit_o       (merge) push will merge rather than allocate
// -----------------------------------------------------------------------------
module st_drain_fifo
    import dcache_store_drain_pkg::*;
#(
    parameter int unsigned DEPTH = ST_DRAIN_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  st_drain_entry_t          push_entry_i,
    input  logic                     pop_i,
`ifdef STORE_MERGE_EN
    input  logic                     tail_busy_i,
    output logic                     merge_cand_o,
    output logic                     merge_hit_o,
`endif
    output st_drain_entry_t          head_o,
    output st_drain_entry_t          next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q, count_d;
    st_drain_entry_t  mem_q [DEPTH];
    logic             alloc;

    assign rd_next = rd_ptr_q + PTR_W'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_next];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] tail_ptr;
    st_drain_entry_t  tail_entry;
    st_drain_entry_t  merged_entry;

    assign tail_ptr     = wr_ptr_q - PTR_W'(1);
    assign tail_entry   = mem_q[tail_ptr];
    assign merge_cand_o = (count_q != '0) &&
                          (tail_entry.addr[ST_DRAIN_ADDR_W-1:3] == push_entry_i.addr[ST_DRAIN_ADDR_W-1:3]);
    assign merge_hit_o  = merge_cand_o && !tail_busy_i;
    assign alloc        = push_i && !merge_hit_o;

    always_comb begin
        merged_entry      = tail_entry;
        merged_entry.data = merge_bytes(tail_entry.data, push_entry_i.data, push_entry_i.be);
        merged_entry.be   = tail_entry.be | push_entry_i.be;
        merged_entry.size = 2'd3;
    end
`else
    assign alloc = push_i;
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (alloc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_next;
        end
        case ({alloc, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/counter.
    always_ff @(posedge clk_i) begin
`ifdef STORE_MERGE_EN
        if (alloc) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end else if (push_i) begin
            mem_q[tail_ptr] <= merged_entry;
        end
`else
        if (alloc) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
`endif
    end

endmodule

// File: rtl/dcache_store_drain.sv
// -----------------------------------------------------------------------------
// dcache_store_drain
// Committed-store buffer in front of the dcache write port. Stores are queued
// in order and drained one at a time; a store retires on data_gnt.
// Optional feature macro: STORE_MERGE_EN (same-double-word tail merge).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   st_valid_i     committed store offered
//   st_ready_o     buffer can accept (registered-state based)
//   st_addr_i      store byte address
//   st_data_i      lane-aligned store data
//   st_be_i        byte enables
//   st_size_i      0=B 1=H 2=W 3=D
//   req_port_o     dcache request
//   req_port_i     dcache response (only data_gnt is used)
//   empty_o        nothing buffered and nothing in flight
//   usage_o        occupied entries including the head being issued
// -----------------------------------------------------------------------------
module dcache_store_drain
    import dcache_store_drain_pkg::*;
#(
    parameter int unsigned DEPTH  = ST_DRAIN_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    input  logic [ADDR_W-1:0]      st_addr_i,
    input  logic [63:0]            st_data_i,
    input  logic [7:0]             st_be_i,
    input  logic [1:0]             st_size_i,
    output dcache_req_i_t          req_port_o,
    input  dcache_req_o_t          req_port_i,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] usage_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    drain_state_e    state_q;
    st_drain_entry_t out_q;
    logic            req_q;

    st_drain_entry_t push_entry;
    st_drain_entry_t head, next;
    logic [CNT_W-1:0] count;
    logic            full;
    logic            push, pop, gnt;
    logic            unused_bits;

    assign gnt  = req_port_i.data_gnt;
    assign pop  = (state_q == DRAIN_REQ) && gnt;
    assign push = st_valid_i && st_ready_o;

    always_comb begin
        push_entry                   = '0;
        push_entry.addr[ADDR_W-1:0]  = st_addr_i;
        push_entry.data              = st_data_i;
        push_entry.be                = st_be_i;
        push_entry.size              = st_size_i;
    end

`ifdef STORE_MERGE_EN
    logic merge_cand, merge_hit, tail_busy;

    // The tail is off limits once it is the head (count==1: issued or being
    // loaded) or when it becomes the next head on this grant (count==2).
    assign tail_busy = (count == CNT_W'(1)) ||
                       ((count == CNT_W'(2)) && pop);

    // Ready uses the gnt-independent candidate only; if a full DEPTH=2 buffer
    // loses the merge to a grant, the same-cycle pop frees the slot it needs.
    assign st_ready_o = !full || merge_cand;

    st_drain_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .tail_busy_i  (tail_busy),
        .merge_cand_o (merge_cand),
        .merge_hit_o  (merge_hit),
        .head_o       (head),
        .next_o       (next),
        .count_o      (count),
        .full_o       (full)
    );

    assign unused_bits = ^{req_port_i.data_rvalid, req_port_i.data_rdata,
                           out_q.addr[ST_DRAIN_ADDR_W-1:DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH],
                           merge_hit};
`else
    assign st_ready_o = !full;

    st_drain_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .next_o       (next),
        .count_o      (count),
        .full_o       (full)
    );

    assign unused_bits = ^{req_port_i.data_rvalid, req_port_i.data_rdata,
                           out_q.addr[ST_DRAIN_ADDR_W-1:DCACHE_INDEX_WIDTH+DCACHE_TAG_WIDTH]};
`endif

    assign usage_o = count;
    assign empty_o = (count == '0) && (state_q == DRAIN_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DRAIN_IDLE;
            out_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (count != '0) begin
                        out_q   <= head;
                        req_q   <= 1'b1;
                        state_q <= DRAIN_REQ;
                    end
                end
                DRAIN_REQ: begin
                    if (gnt) begin
                        if (count > CNT_W'(1)) begin
                            out_q <= next;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= DRAIN_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= DRAIN_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        req_port_o               = '0;
        req_port_o.address_index = out_q.addr[DCACHE_INDEX_WIDTH-1:0];
        req_port_o.address_tag   = out_q.addr[DCACHE_INDEX_WIDTH +: DCACHE_TAG_WIDTH];
        req_port_o.data_wdata    = out_q.data;
        req_port_o.data_be       = out_q.be;
        req_port_o.data_size     = out_q.size;
        req_port_o.data_req      = req_q;
        req_port_o.data_we       = req_q;
        req_port_o.tag_valid     = req_q;
        req_port_o.kill_req      = 1'b0;
    end

endmodule

// File: tb/tb_dcache_store_drain.sv
module tb_dcache_store_drain;
    import dcache_store_drain_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 64;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          st_valid_i;
    logic          st_ready_o;
    logic [63:0]   st_addr_i;
    logic [63:0]   st_data_i;
    logic [7:0]    st_be_i;
    logic [1:0]    st_size_i;
    dcache_req_i_t req_port_o;
    dcache_req_o_t rsp;
    logic          empty_o;
    logic [2:0]    usage_o;

    int checks = 0;
    int errors = 0;
    dcache_req_i_t exp_q[$];
    dcache_req_i_t exp_r;

    always #5 clk_i = ~clk_i;

    dcache_store_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .st_valid_i (st_valid_i),
        .st_ready_o (st_ready_o),
        .st_addr_i  (st_addr_i),
        .st_data_i  (st_data_i),
        .st_be_i    (st_be_i),
        .st_size_i  (st_size_i),
        .req_port_o (req_port_o),
        .req_port_i (rsp),
        .empty_o    (empty_o),
        .usage_o    (usage_o)
    );

    function automatic dcache_req_i_t mk(input logic [63:0] a, input logic [63:0] d,
                                         input logic [7:0] be, input logic [1:0] sz);
        dcache_req_i_t r;
        r               = '0;
        r.address_index = a[11:0];
        r.address_tag   = a[55:12];
        r.data_wdata    = d;
        r.data_be       = be;
        r.data_size     = sz;
        r.data_req      = 1'b1;
        r.data_we       = 1'b1;
        r.tag_valid     = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every granted request must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && req_port_o.data_req && rsp.data_gnt) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got request %h with none expected", req_port_o);
            end else begin
                exp_r = exp_q.pop_front();
                if (req_port_o !== exp_r) begin
                    errors++;
                    $display("FAIL sb_req: got %h expected %h", req_port_o, exp_r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                        input logic [1:0] sz, input bit track);
        int unsigned n;
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_be_i    = be;
        st_size_i  = sz;
        n = 0;
        @(negedge clk_i);
        while (!st_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("push_ready", {63'b0, st_ready_o}, 64'd1);
        tick();
        st_valid_i = 1'b0;
        if (track) exp_q.push_back(mk(a, d, be, sz));
    endtask

    // Called at posedge+1: grant until the buffer reports empty, bounded.
    task automatic drain(input string name);
        int unsigned n;
        rsp.data_gnt = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!empty_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check(name, {63'b0, empty_o}, 64'd1);
        tick();
        rsp.data_gnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        dcache_req_i_t snap;
        logic [3:0]    pat;
        int            cnt;

        st_valid_i       = 1'b0;
        st_addr_i        = '0;
        st_data_i        = '0;
        st_be_i          = '0;
        st_size_i        = '0;
        rsp              = '0;
        rsp.data_rvalid  = 1'b1;
        rsp.data_rdata   = 64'hDEAD_BEEF_0BAD_F00D;

        #1 rst_i = 1'b1;
        #2;
        check("rst_req_zero", {63'b0, |req_port_o}, 64'd0);
        check("rst_ready", {63'b0, st_ready_o}, 64'd1);
        check("rst_empty", {63'b0, empty_o}, 64'd1);
        check("rst_usage", {61'b0, usage_o}, 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // 1: single store with grant held high
        rsp.data_gnt = 1'b1;
        push(64'h8000_1010, 64'hAABB, 8'h03, 2'd1, 1'b1);
        @(negedge clk_i);
        check("t1_req_not_yet", {63'b0, req_port_o.data_req}, 64'd0);
        @(negedge clk_i);
        check("t1_req", {63'b0, req_port_o.data_req}, 64'd1);
        check("t1_index", {52'b0, req_port_o.address_index}, 64'h010);
        check("t1_tag", {20'b0, req_port_o.address_tag}, 64'h80001);
        check("t1_be", {56'b0, req_port_o.data_be}, 64'h03);
        @(negedge clk_i);
        check("t1_req_drop", {63'b0, req_port_o.data_req}, 64'd0);
        check("t1_empty", {63'b0, empty_o}, 64'd1);
        tick();
        rsp.data_gnt = 1'b0;

        // 2: grant stall then back-to-back grants
        push(64'h1000, 64'h1111, 8'hFF, 2'd3, 1'b1);
        push(64'h2008, 64'h2222, 8'hFF, 2'd3, 1'b1);
        push(64'h3FF8, 64'h3333, 8'hFF, 2'd3, 1'b1);
        @(negedge clk_i);
        snap = req_port_o;
        check("t2_req_held", {63'b0, snap.data_req}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (req_port_o !== snap) begin
                errors++;
                $display("FAIL t2_stable: got %h expected %h", req_port_o, snap);
            end
        end
        tick();
        rsp.data_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            pat[3-i] = req_port_o.data_req;
        end
        check("t2_b2b", {60'b0, pat}, 64'b1110);
        tick();
        rsp.data_gnt = 1'b0;

        // 3: fill to DEPTH, fifth store waits for one grant
        for (int i = 0; i < 4; i++) begin
            push(64'h4000 + 64'(i * 8), 64'h4000 + 64'(i), 8'hFF, 2'd3, 1'b1);
        end
        @(negedge clk_i);
        check("t3_ready_full", {63'b0, st_ready_o}, 64'd0);
        check("t3_usage_full", {61'b0, usage_o}, 64'd4);
        tick();
        st_valid_i = 1'b1;
        st_addr_i  = 64'h4020;
        st_data_i  = 64'h4004;
        st_be_i    = 8'hFF;
        st_size_i  = 2'd3;
        rsp.data_gnt = 1'b1;
        @(negedge clk_i);
        check("t3_ready_gnt_cycle", {63'b0, st_ready_o}, 64'd0);
        tick();
        rsp.data_gnt = 1'b0;
        @(negedge clk_i);
        check("t3_ready_after_pop", {63'b0, st_ready_o}, 64'd1);
        check("t3_usage_after_pop", {61'b0, usage_o}, 64'd3);
        tick();
        st_valid_i = 1'b0;
        exp_q.push_back(mk(64'h4020, 64'h4004, 8'hFF, 2'd3));
        @(negedge clk_i);
        check("t3_usage_refill", {61'b0, usage_o}, 64'd4);
        tick();
        drain("t3_drain");

        // 4: asynchronous reset while a request is stalled
        push(64'h5000, 64'h5555, 8'hFF, 2'd3, 1'b0);
        push(64'h5008, 64'h5556, 8'hFF, 2'd3, 1'b0);
        @(negedge clk_i);
        check("t4_req_pre", {63'b0, req_port_o.data_req}, 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("t4_req_async", {63'b0, req_port_o.data_req}, 64'd0);
        check("t4_usage_async", {61'b0, usage_o}, 64'd0);
        check("t4_empty_async", {63'b0, empty_o}, 64'd1);
        tick();
        rst_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            cnt += int'(req_port_o.data_req);
        end
        check("t4_no_stale", 64'(cnt), 64'd0);
        tick();

        // 5: same-double-word stores behind a stalled head
        push(64'h200, 64'hCAFE, 8'hFF, 2'd3, 1'b1);
        push(64'h100, 64'h0000_0000_4433_2211, 8'h0F, 2'd2, 1'b1);
`ifdef STORE_MERGE_EN
        push(64'h104, 64'h8877_6655_0000_0000, 8'hF0, 2'd2, 1'b0);
        void'(exp_q.pop_back());
        exp_q.push_back(mk(64'h100, 64'h8877_6655_4433_2211, 8'hFF, 2'd3));
        @(negedge clk_i);
        check("t5_usage", {61'b0, usage_o}, 64'd2);
`else
        push(64'h104, 64'h8877_6655_0000_0000, 8'hF0, 2'd2, 1'b1);
        @(negedge clk_i);
        check("t5_usage", {61'b0, usage_o}, 64'd3);
`endif
        tick();
        drain("t5_drain");

        // 6: push and grant in the same cycle at usage 2
        push(64'h6000, 64'h6660, 8'hFF, 2'd3, 1'b1);
        push(64'h6010, 64'h6661, 8'hFF, 2'd3, 1'b1);
        @(negedge clk_i);
        check("t6_usage_pre", {61'b0, usage_o}, 64'd2);
        tick();
        rsp.data_gnt = 1'b1;
        push(64'h6020, 64'h6662, 8'hFF, 2'd3, 1'b1);
        rsp.data_gnt = 1'b0;
        @(negedge clk_i);
        check("t6_usage", {61'b0, usage_o}, 64'd2);
        tick();
        drain("t6_drain");

        check("sb_all_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
